// File: rtl/shift_frame_ctrl_pkg.sv
// Shared types and defaults for the shift frame controller.
package shift_frame_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_load.sv
// Parallel-load shift register: serial in at the MSB, serial out from bit 0.
module shift_reg_load
  import shift_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shreg_q;

  // Load wins over shift; the controller never asserts both together.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= load_data;
    end else if (shift_en) begin
      shreg_q <= {sin, shreg_q[WIDTH-1:1]};
    end
  end

  assign sout = shreg_q[0];
  assign q    = shreg_q;

endmodule

// File: rtl/shift_frame_ctrl.sv
// LSB-first serial frame engine: loads a word, shifts WIDTH bits out/in, reports the received word.
module shift_frame_ctrl
  import shift_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             Sin,
  output logic             Sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             shift_en
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] shreg;
  logic             load;
  logic             shift;

  shift_reg_load #(
    .WIDTH (WIDTH)
  ) u_shift_reg_load (
    .clk       (Clock),
    .reset     (reset),
    .load      (load),
    .load_data (tx_data),
    .shift_en  (shift),
    .sin       (Sin),
    .sout      (Sout),
    .q         (shreg)
  );

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        // Final shift: capture the word as it will look after this edge.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = DONE;
          rx_d    = {Sin, shreg[WIDTH-1:1]};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign shift_en = (state_q == SHIFT);
  assign rx_data  = rx_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench: fixed frame vectors, corner sequences and random traffic against a frame model.
module tb_shift_frame_ctrl;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         Sin = 1'b0;
  logic         Sout;
  logic         busy;
  logic         done;
  logic [W-1:0] rx_data;
  logic         shift_en;

  always #5 Clock = ~Clock;

  shift_frame_ctrl #(
    .WIDTH (W)
  ) dut (
    .Clock    (Clock),
    .reset    (reset),
    .start    (start),
    .tx_data  (tx_data),
    .Sin      (Sin),
    .Sout     (Sout),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .shift_en (shift_en)
  );

  typedef struct {
    string        name;
    logic [W-1:0] tx;
    logic [W-1:0] sin_bits;  // bit j-1 driven at shift edge j
    logic [W-1:0] exp_sout;  // bit j-1 expected on Sout during shift cycle j
    logic [W-1:0] exp_rx;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  // Frame model: phase -1 = no frame, 0..W-1 = bits already shifted, W = completion cycle.
  int           phase = -1;
  logic [W-1:0] m_tx = '0;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] m_rx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_sout();
    if (phase >= 0 && phase < W) return m_tx[phase];
    return m_rx[0];
  endfunction

  task automatic step(input logic r, input logic st, input logic [W-1:0] txd, input logic s);
    reset = r;
    start = st;
    tx_data = txd;
    Sin = s;
    @(posedge Clock);
    if (r) begin
      phase = -1;
      m_rx = '0;
    end else if (phase < 0) begin
      if (st) begin
        phase = 0;
        m_tx = txd;
        m_acc = '0;
      end
    end else if (phase < W) begin
      m_acc[phase] = s;
      phase++;
      if (phase == W) m_rx = m_acc;
    end else begin
      phase = -1;
    end
    @(negedge Clock);
    check("model_sout", Sout, exp_sout());
    check("model_busy", busy, phase >= 0);
    check("model_done", done, phase == W);
    check("model_shift_en", shift_en, phase >= 0 && phase < W);
    check("model_rx", rx_data, m_rx);
    if (done === 1'b1) done_seen++;
  endtask

  vec_t vecs[3];

  initial begin
    int busy_n;
    int dones0;
    int last_done;
    logic s;

    vecs[0] = '{"loopback_a5", 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{"zero_tx_ones_in", 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{"sin_pattern_53", 8'h3C, 8'h53, 8'h3C, 8'h53};

    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("reset_sout", Sout, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_shift_en", shift_en, 0);
    check("reset_rx", rx_data, 0);

    foreach (vecs[v]) begin
      step(1'b0, 1'b1, vecs[v].tx, 1'b0);
      busy_n = int'(busy);
      for (int j = 1; j <= W; j++) begin
        check({vecs[v].name, "_sout"}, Sout, vecs[v].exp_sout[j-1]);
        step(1'b0, 1'b0, 8'h00, vecs[v].sin_bits[j-1]);
        busy_n += int'(busy);
      end
      check({vecs[v].name, "_done"}, done, 1);
      check({vecs[v].name, "_rx"}, rx_data, vecs[v].exp_rx);
      check({vecs[v].name, "_busy_cycles"}, busy_n, W + 1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check({vecs[v].name, "_idle_busy"}, busy, 0);
    end

    // Start re-asserted mid-frame with a different word must not reload or queue.
    dones0 = done_seen;
    step(1'b0, 1'b1, 8'h96, 1'b0);
    for (int j = 1; j <= W; j++) begin
      step(1'b0, (j == 3 || j == W), 8'hFF, 1'($urandom_range(0, 1)));
    end
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("restart_ignored_dones", done_seen - dones0, 1);

    // Reset mid-frame aborts without a done pulse.
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    for (int j = 1; j <= 3; j++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("abort_sout", Sout, 0);
    check("abort_busy", busy, 0);
    check("abort_rx", rx_data, 0);
    dones0 = done_seen;
    for (int j = 0; j < 10; j++) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("abort_no_done", done_seen - dones0, 0);

    // Start held high: frames back to back every W+2 cycles.
    dones0 = done_seen;
    last_done = -1;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 1'b1, 8'h3C, 1'($urandom_range(0, 1)));
      if (done === 1'b1) begin
        if (last_done >= 0) check("held_start_spacing", c - last_done, W + 2);
        last_done = c;
      end
    end
    check("held_start_dones", done_seen - dones0, 3);
    for (int j = 0; j < W + 2; j++) step(1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic against the frame model.
    for (int c = 0; c < 400; c++) begin
      s = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), W'($urandom), s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
